// File: rtl/hex_debug_ctrl.sv
// Debug-word display feeder for six HexDriver digits: rate-limited capture, debounced freeze toggle,
// page select and leading-zero blanking. Optional frozen-display blink: HEX_DEBUG_FREEZE_BLINK_EN.
module hex_debug_ctrl #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned REFRESH_HZ      = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_valid,
    input  logic [31:0] dbg_data,
    input  logic        freeze_key_n,
    input  logic        page_sel,
    input  logic        blank_en,
    output logic [3:0]  hex_num_0,
    output logic [3:0]  hex_num_1,
    output logic [3:0]  hex_num_2,
    output logic [3:0]  hex_num_3,
    output logic [3:0]  hex_num_4,
    output logic [3:0]  hex_num_5,
    output logic [5:0]  hex_blank,
    output logic        frozen,
    output logic        update_pulse
);

    localparam int unsigned TICK_DIV_RAW = CLK_HZ / REFRESH_HZ;
    localparam int unsigned TICK_DIV     = (TICK_DIV_RAW < 2) ? 2 : TICK_DIV_RAW;
    localparam int unsigned TICK_W       = $clog2(TICK_DIV);
    localparam int unsigned DB_W         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              load_c;
    logic              tick_c;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [31:0]       latest_q;
    logic [31:0]       shown_q;

    logic              key_meta_q, key_sync_q;
    logic [1:0]        sync_fill_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              key_acc_q, key_acc_d_q;
    logic              armed_q;
    logic              press_q;

    logic [5:0][3:0]   nib_c;
    logic [5:0]        forced_c;
    logic [5:0]        blank_c;
    logic              seen_c;
    logic              blink_dark_c;

    // Free-running refresh divider; never restarted by freeze/run.
    assign tick_c = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick_c) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Synchronizer + debouncer; armed only after a released key has been seen so a key
    // held through reset cannot produce a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q  <= 1'b1;
            key_sync_q  <= 1'b1;
            sync_fill_q <= 2'b00;
            db_cnt_q    <= '0;
            key_acc_q   <= 1'b1;
            key_acc_d_q <= 1'b1;
            armed_q     <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            key_meta_q  <= freeze_key_n;
            key_sync_q  <= key_meta_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            armed_q     <= armed_q | (sync_fill_q[1] & key_sync_q);
            key_acc_d_q <= key_acc_q;
            press_q     <= armed_q & key_acc_d_q & ~key_acc_q;
            if (key_sync_q == key_acc_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_acc_q <= key_sync_q;
                db_cnt_q  <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Press wins over a coincident tick: freeze without loading.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (press_q) begin
                    state_d = ST_FROZEN;
                end else if (tick_c) begin
                    load_c = 1'b1;
                end
            end
            ST_FROZEN: begin
                if (press_q) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latest_q     <= '0;
            shown_q      <= '0;
            update_pulse <= 1'b0;
            frozen       <= 1'b0;
        end else begin
            if (dbg_valid) begin
                latest_q <= dbg_data;
            end
            if (load_c) begin
                shown_q <= dbg_valid ? dbg_data : latest_q;
            end
            update_pulse <= load_c;
            frozen       <= (state_d == ST_FROZEN);
        end
    end

`ifdef HEX_DEBUG_FREEZE_BLINK_EN
    localparam int unsigned BLINK_W = (REFRESH_HZ > 1) ? $clog2(REFRESH_HZ) : 1;

    logic [BLINK_W-1:0] blink_q;

    // Tick-rate blink phase, restarted on each freeze entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
        end else if (state_q == ST_RUN && state_d == ST_FROZEN) begin
            blink_q <= '0;
        end else if (tick_c) begin
            blink_q <= (blink_q == BLINK_W'(REFRESH_HZ - 1)) ? '0 : blink_q + BLINK_W'(1);
        end
    end

    assign blink_dark_c = (state_q == ST_FROZEN) && (blink_q >= BLINK_W'(REFRESH_HZ / 2));
`else
    assign blink_dark_c = 1'b0;
`endif

    // Page mapping and leading-zero blanking from the top visible digit down; digit 0 always lit.
    always_comb begin
        nib_c    = '0;
        forced_c = '0;
        if (page_sel) begin
            nib_c[0] = shown_q[27:24];
            nib_c[1] = shown_q[31:28];
            forced_c = 6'b111100;
        end else begin
            for (int i = 0; i < 6; i++) begin
                nib_c[i] = shown_q[4*i +: 4];
            end
        end
        blank_c = forced_c;
        seen_c  = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            if (!forced_c[i]) begin
                if (nib_c[i] != 4'h0) begin
                    seen_c = 1'b1;
                end else if (blank_en && !seen_c) begin
                    blank_c[i] = 1'b1;
                end
            end
        end
        if (blink_dark_c) begin
            blank_c = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_num_0 <= '0;
            hex_num_1 <= '0;
            hex_num_2 <= '0;
            hex_num_3 <= '0;
            hex_num_4 <= '0;
            hex_num_5 <= '0;
            hex_blank <= '0;
        end else begin
            hex_num_0 <= nib_c[0];
            hex_num_1 <= nib_c[1];
            hex_num_2 <= nib_c[2];
            hex_num_3 <= nib_c[3];
            hex_num_4 <= nib_c[4];
            hex_num_5 <= nib_c[5];
            hex_blank <= blank_c;
        end
    end

endmodule

// File: doc/hex_debug_ctrl.md
# hex_debug_ctrl

Upstream feeder for the board's six `HexDriver` instances: captures a 32-bit debug word from the core, for example the PC or a register tap, and rate-limits display updates to a human-readable refresh rate. It also provides a debounced freeze/run toggle from a push-button, and selects which page of the word is shown. It emits one registered 4-bit nibble plus one blank flag per digit, consumed directly by the `HexDriver` instances in the board top level.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `REFRESH_HZ`, 10, display update rate; `TICK_DIV = CLK_HZ/REFRESH_HZ`, minimum 2.
- `DEBOUNCE_CYCLES`, 500_000, cycles the synchronized key must hold a level before it is accepted (10 ms at 50 MHz).
- `clk`  in  1  system clock (`MAX10_CLK1_50` at top level).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dbg_valid`  in  1  qualifies `dbg_data` this cycle.
- `dbg_data`  in  32  debug word.
- `freeze_key_n`  in  1  raw, asynchronous, active-low push-button (`KEY[1]`).
- `page_sel`  in  1  0: show bits [23:0]; 1: show bits [31:24].
- `blank_en`  in  1  enables leading-zero blanking.
- `hex_num_0` … `hex_num_5`  out  4 each  digit nibbles; digit 0 is least significant.
- `hex_blank`  out  6  bit i = 1 means digit i is dark.
- `frozen`  out  1  high while in FROZEN.
- `update_pulse`  out  1  one-cycle pulse whenever `shown_q` loads.

## Operation
- **latest_q** (32 bits)
  - Loads `dbg_data` on every `dbg_valid`, in both RUN and FROZEN.
- **Tick counter**
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is asserted when count == TICK_DIV-1.
- **shown_q, RUN state**
  - On `tick`, loads `dbg_valid ? dbg_data : latest_q`; new data bypasses `latest_q` on a coincident cycle.
  - Asserts `update_pulse` on the same edge.
- **shown_q, FROZEN state**
  - Holds; ticks are ignored and `update_pulse` stays 0.
- **Debounce**
  - 2-flop synchronizer, then a counter that resets whenever the synchronized level differs from the accepted level.
  - Accepted level changes when the counter reaches DEBOUNCE_CYCLES-1.
  - `press` is a one-cycle pulse on an accepted 1→0 transition.
- **FSM states**
  - RUN → FROZEN on `press`.
  - FROZEN → RUN on `press`.
  - `press` and `tick` in the same cycle in RUN: the state goes to FROZEN and `shown_q` does not load.
- **Page mapping**
  - Page 0: digit i = `shown_q[4i+3:4i]`.
  - Page 1: digits 0–1 = `shown_q[31:24]`; digits 2–5 = 0 with blank forced to 1.
- **Blanking** (`blank_en` = 1)
  - Starting at the most significant visible digit, each 0 digit is blanked until the first nonzero digit.
  - Digit 0 is never blanked.
  - With `blank_en` = 0, only the page-1 forced blanks apply.
- **Output registers**
  - `hex_num_*` and `hex_blank` are registered.
  - They are recomputed every cycle from `shown_q`, `page_sel` and `blank_en`, so a `page_sel` or `blank_en` change is visible after 1 cycle.
- **Reset values**
  - `hex_num_*` = 0, `hex_blank` = 0, `frozen` = 0, `update_pulse` = 0.
  - `latest_q` = 0, `shown_q` = 0; tick and debounce counters = 0.
  - Accepted key level = 1 (released); state = RUN.
- **Reset mid-operation**
  - All of the above return to reset values immediately.
  - A key held low through reset release produces no `press` until it is released and pressed again.

## Timing
- First `tick` comes TICK_DIV cycles after `rst_n` deasserts.
- Ticks then repeat every TICK_DIV cycles.
- `dbg_valid` → `hex_num_*` worst-case latency: TICK_DIV + 1 cycles; best case: 1 cycle (coincident with `tick`, then the output register).
- `update_pulse` is asserted in the cycle `shown_q` is loaded, so it leads the corresponding `hex_num_*` change by 1 cycle.
- Key edge → `press`: 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles.
- `press` → `frozen` change: 1 cycle.
- FROZEN → RUN: the display refreshes at the next `tick`; the tick counter runs continuously and is never restarted.
- Key bounce shorter than DEBOUNCE_CYCLES produces no `press`.

## Configuration
- `HEX_DEBUG_FREEZE_BLINK_EN`
- **Defined:** a free-running blink counter is added with a period of REFRESH_HZ ticks (1 s).
  - While FROZEN, `hex_blank` is forced to 6'b111111 during the second half of each period (ticks REFRESH_HZ/2 .. REFRESH_HZ-1).
  - The blink counter clears on entry to FROZEN.
  - RUN behaviour is unchanged.
- **Undefined:** no blink counter; the FROZEN display is steady.

## Test plan
Bench parameters: CLK_HZ=100, REFRESH_HZ=10 (TICK_DIV=10), DEBOUNCE_CYCLES=4.

- **Reset values:** reset, then hold `dbg_valid`=0 → all outputs 0, `frozen`=0; first `update_pulse` at cycle 10 after reset release.
- **Update latency and page 0:** `dbg_data`=0x12345678 valid at cycle 3 → at the cycle-10 tick, `shown_q` = 0x12345678; one cycle later `hex_num_5..0` = 3,4,5,6,7,8; with `page_sel`=1, digits 1,0 = 1,2 and `hex_blank`=6'b111100.
- **Leading-zero blanking:** word 0x00000A05, `blank_en`=1, page 0 → `hex_blank`=6'b111000; word 0 → `hex_blank`=6'b111110.
- **Freeze and resume:** key low for 6 cycles → `frozen`=1 at 2+4+1+1 cycles after the edge. New words then produce no `update_pulse` and a held display. A second press → RUN, and the next tick shows the last captured word.
- **Bounce and simultaneous events:** key low for 3 cycles → no `press`. A `press` coincident with a `tick` in RUN → `frozen`=1 and `shown_q` unchanged. `dbg_valid` coincident with a `tick` → the new `dbg_data` is shown.
- **Blink (macro defined):** frozen → `hex_blank` = all-ones for ticks 5..9 of each 10-tick period. Mid-freeze reset → `frozen`=0 and outputs = 0.
